control_ordenamiento: RTL and testbench

- Sequential sort controller. Holds N unsigned WIDTH-bit values and sorts them into ascending order with a bubble sort.
- Shares one external "greater-than" comparator (the team's 4-bit `mayor` block): the controller drives the comparator's A/B operands and consumes its F result.
- Data is loaded serially, sorting starts on a start pulse, and a one-cycle done pulse signals completion.
- Sits between a data source (switches/bench) and the comparator datapath.

---
 rtl/ordenamiento_pkg.sv | 14 +
 rtl/banco_registros.sv | 44 ++++
 rtl/mayor.sv | 13 +
 rtl/control_ordenamiento.sv | 136 +++++++++++++
 tb/tb_control_ordenamiento.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ordenamiento_pkg.sv
// Shared types and defaults for the bubble-sort controller.
// No logic; state encoding and default sizing only.
package ordenamiento_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int N_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARA = 2'd1,
        ST_FIN     = 2'd2
    } estado_t;

endpackage

// File: rtl/banco_registros.sv
// N x WIDTH slot file: indexed load, swap of slots idx/idx+1, flattened view.
// Latency: writes/swaps land at the next edge; reads are combinational. Backpressure: none.
module banco_registros #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int AW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               carga_en,
    input  logic [AW-1:0]      idx_carga,
    input  logic [WIDTH-1:0]   dato,
    input  logic               swap,
    input  logic [AW-1:0]      idx_cmp,
    output logic [WIDTH-1:0]   rd_a,
    output logic [WIDTH-1:0]   rd_b,
    output logic [N*WIDTH-1:0] datos_out
);

    logic [WIDTH-1:0] slot [N];
    logic [AW-1:0]    idx_sig;

    assign idx_sig = idx_cmp + AW'(1);
    assign rd_a    = slot[idx_cmp];
    assign rd_b    = slot[idx_sig];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                slot[i] <= '0;
            end
        end else if (carga_en) begin
            slot[idx_carga] <= dato;
        end else if (swap) begin
            slot[idx_cmp] <= slot[idx_sig];
            slot[idx_sig] <= slot[idx_cmp];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign datos_out[g*WIDTH +: WIDTH] = slot[g];
    end

endmodule

// File: rtl/mayor.sv
// Unsigned greater-than comparator shared by the sort controller.
// Latency: combinational. Backpressure: none.
module mayor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             f
);

    assign f = (a > b);

endmodule

// File: rtl/control_ordenamiento.sv
// Bubble-sort controller driving an external greater-than comparator; EARLY_EXIT_EN stops after a swap-free pass.
// Latency: N(N-1)/2 compare cycles after start, then a one-cycle done pulse. Backpressure: carga/start ignored while sorting.
module control_ordenamiento
    import ordenamiento_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N     = N_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               carga,
    input  logic [WIDTH-1:0]   dato_in,
    input  logic               start,
    output logic [WIDTH-1:0]   cmp_a,
    output logic [WIDTH-1:0]   cmp_b,
    input  logic               cmp_gt,
    output logic [N*WIDTH-1:0] datos_out,
    output logic               busy,
    output logic               done
);

    localparam int            AW          = $clog2(N);
    localparam logic [AW-1:0] ULTIMO_PASS = AW'(N - 2);
    localparam logic [AW-1:0] ULTIMO_PTR  = AW'(N - 1);

    estado_t       estado, estado_sig;
    logic [AW-1:0] pass_q, pass_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          carga_en, swap, fin_sort;
    logic [WIDTH-1:0] rd_a, rd_b;
`ifdef EARLY_EXIT_EN
    logic          hubo_swap_q, hubo_swap_d;
`endif

    banco_registros #(
        .WIDTH (WIDTH),
        .N     (N),
        .AW    (AW)
    ) u_banco (
        .clk       (clk),
        .rst       (rst),
        .carga_en  (carga_en),
        .idx_carga (ptr_q),
        .dato      (dato_in),
        .swap      (swap),
        .idx_cmp   (j_q),
        .rd_a      (rd_a),
        .rd_b      (rd_b),
        .datos_out (datos_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= ST_IDLE;
            pass_q <= '0;
            j_q    <= '0;
            ptr_q  <= '0;
`ifdef EARLY_EXIT_EN
            hubo_swap_q <= 1'b0;
`endif
        end else begin
            estado <= estado_sig;
            pass_q <= pass_d;
            j_q    <= j_d;
            ptr_q  <= ptr_d;
`ifdef EARLY_EXIT_EN
            hubo_swap_q <= hubo_swap_d;
`endif
        end
    end

    always_comb begin
        estado_sig = estado;
        pass_d     = pass_q;
        j_d        = j_q;
        ptr_d      = ptr_q;
        carga_en   = 1'b0;
        swap       = 1'b0;
        fin_sort   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cmp_a      = '0;
        cmp_b      = '0;
`ifdef EARLY_EXIT_EN
        hubo_swap_d = hubo_swap_q;
`endif
        case (estado)
            ST_IDLE: begin
                // start has priority; a simultaneous load is dropped
                if (start) begin
                    estado_sig = ST_COMPARA;
                    pass_d     = '0;
                    j_d        = '0;
`ifdef EARLY_EXIT_EN
                    hubo_swap_d = 1'b0;
`endif
                end else if (carga) begin
                    carga_en = 1'b1;
                    ptr_d    = (ptr_q == ULTIMO_PTR) ? '0 : ptr_q + AW'(1);
                end
            end
            ST_COMPARA: begin
                busy  = 1'b1;
                cmp_a = rd_a;
                cmp_b = rd_b;
                swap  = cmp_gt;
`ifdef EARLY_EXIT_EN
                hubo_swap_d = hubo_swap_q | cmp_gt;
                fin_sort    = (pass_q == ULTIMO_PASS) || !(hubo_swap_q || cmp_gt);
`else
                fin_sort    = (pass_q == ULTIMO_PASS);
`endif
                if (j_q == ULTIMO_PASS - pass_q) begin
                    if (fin_sort) begin
                        estado_sig = ST_FIN;
                    end else begin
                        pass_d = pass_q + AW'(1);
                        j_d    = '0;
`ifdef EARLY_EXIT_EN
                        hubo_swap_d = 1'b0;
`endif
                    end
                end else begin
                    j_d = j_q + AW'(1);
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                estado_sig = ST_IDLE;
            end
            default: estado_sig = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_ordenamiento.sv
// Directed bench for control_ordenamiento with the mayor comparator in the loop.
// Expected cycle counts follow EARLY_EXIT_EN when it is defined for the build.
module tb_control_ordenamiento;

`ifdef EARLY_EXIT_EN
    localparam int CIC_ORDENADO = 3;
    localparam int CIC_WRAP     = 5;
`else
    localparam int CIC_ORDENADO = 6;
    localparam int CIC_WRAP     = 6;
`endif
    localparam int CIC_COMPLETO = 6;

    logic        clk;
    logic        rst;
    logic        carga;
    logic [3:0]  dato_in;
    logic        start;
    logic [3:0]  cmp_a;
    logic [3:0]  cmp_b;
    logic        cmp_gt;
    logic [15:0] datos_out;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    control_ordenamiento #(.WIDTH(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .carga     (carga),
        .dato_in   (dato_in),
        .start     (start),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_gt    (cmp_gt),
        .datos_out (datos_out),
        .busy      (busy),
        .done      (done)
    );

    mayor #(.WIDTH(4)) u_mayor (
        .a (cmp_a),
        .b (cmp_b),
        .f (cmp_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        carga   = 1'b1;
        dato_in = v;
        tick();
        carga   = 1'b0;
    endtask

    task automatic run_sort(input int ciclos, input logic [15:0] inicial,
                            input logic [15:0] esperado, input string nombre);
        logic [3:0] a0, b0;
        a0 = inicial[3:0];
        b0 = inicial[7:4];
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < ciclos; k++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy/done cycle %0d: busy=%0b done=%0b, required busy=1 done=0",
                         nombre, k + 1, busy, done);
            end
            if (k == 0) begin
                n_cmp++;
                if (cmp_a !== a0 || cmp_b !== b0) begin
                    n_err++;
                    $display("FAIL %s first operands: a=%0d b=%0d, required a=%0d b=%0d",
                             nombre, cmp_a, cmp_b, a0, b0);
                end
            end
            if (cmp_a == cmp_b) begin
                n_cmp++;
                if (cmp_gt !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s equal operands cycle %0d: cmp_gt=%0b, required 0",
                             nombre, k + 1, cmp_gt);
                end
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s done pulse: done=%0b busy=%0b, required done=1 busy=0",
                     nombre, done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done width: done=%0b one cycle later, required 0", nombre, done);
        end
        n_cmp++;
        if (datos_out !== esperado) begin
            n_err++;
            $display("FAIL %s result: datos_out=%h, required %h", nombre, datos_out, esperado);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; carga = 1'b0; start = 1'b0; dato_in = '0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (datos_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset slots: datos_out=%h, required 0000", datos_out);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset flags: busy=%0b done=%0b, required 0 0", busy, done);
        end
        n_cmp++;
        if (cmp_a !== 4'd0 || cmp_b !== 4'd0) begin
            n_err++;
            $display("FAIL reset operands: a=%0d b=%0d, required 0 0", cmp_a, cmp_b);
        end
    endtask

    task automatic test_sort_basic;
        load(4'd8); load(4'd3); load(4'd7); load(4'd1);
        n_cmp++;
        if (datos_out !== 16'h1738) begin
            n_err++;
            $display("FAIL basic load: datos_out=%h, required 1738", datos_out);
        end
        run_sort(CIC_COMPLETO, 16'h1738, 16'h8731, "basic");
    endtask

    task automatic test_sorted;
        load(4'd1); load(4'd2); load(4'd3); load(4'd4);
        run_sort(CIC_ORDENADO, 16'h4321, 16'h4321, "sorted");
    endtask

    task automatic test_equal;
        load(4'd7); load(4'd7); load(4'd3); load(4'd7);
        run_sort(CIC_COMPLETO, 16'h7377, 16'h7773, "equal");
    endtask

    task automatic test_reset_mid;
        int pulsos;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (datos_out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset mid-sort: datos_out=%h busy=%0b done=%0b, required 0000 0 0",
                     datos_out, busy, done);
        end
        pulsos = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) pulsos++;
            tick();
        end
        n_cmp++;
        if (pulsos != 0) begin
            n_err++;
            $display("FAIL reset mid-sort done: %0d pulses, required 0", pulsos);
        end
        load(4'd15); load(4'd0); load(4'd15); load(4'd0);
        run_sort(CIC_COMPLETO, 16'h0F0F, 16'hFF00, "after_reset");
    endtask

    task automatic test_start_carga;
        int pulsos;
        dato_in = 4'd9;
        start   = 1'b1;
        carga   = 1'b1;
        tick();
        start   = 1'b0;
        carga   = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_carga busy: busy=%0b, required 1", busy);
        end
        start = 1'b1;
        carga = 1'b1;
        tick();
        start = 1'b0;
        carga = 1'b0;
        pulsos = 0;
        for (int k = 0; k < 12; k++) begin
            if (done === 1'b1) pulsos++;
            tick();
        end
        n_cmp++;
        if (pulsos != 1) begin
            n_err++;
            $display("FAIL start_carga done count: %0d pulses, required 1", pulsos);
        end
        n_cmp++;
        if (datos_out !== 16'hFF00) begin
            n_err++;
            $display("FAIL start_carga slots: datos_out=%h, required ff00", datos_out);
        end
    endtask

    task automatic test_wrap;
        load(4'd2); load(4'd4); load(4'd6); load(4'd8); load(4'd5);
        n_cmp++;
        if (datos_out !== 16'h8645) begin
            n_err++;
            $display("FAIL wrap load: datos_out=%h, required 8645", datos_out);
        end
        run_sort(CIC_WRAP, 16'h8645, 16'h8654, "wrap");
    endtask

    initial begin
        rst = 1'b1; carga = 1'b0; start = 1'b0; dato_in = '0;
        test_reset();
        test_sort_basic();
        test_sorted();
        test_equal();
        test_reset_mid();
        test_start_carga();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
